// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage.
// Holds the data-path widths, the default MMIO addresses, the read-data
// source selector and the packed MEM/WB control/data bundle.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  localparam logic [WORD_W-1:0] LED_ADDR_DEF = 32'hFFFF_FFF0;
  localparam logic [WORD_W-1:0] SW_ADDR_DEF  = 32'hFFFF_FFF4;

  // Which source drives ReadData once the MEM/WB register has loaded.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_SW   = 2'd2
  } rd_src_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [WORD_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } memwb_t;

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM.
// Synchronous write, synchronous read; a read and a write to the same
// index on the same edge returns the old contents.
// Ports:
//   clk    in  clock
//   en     in  read enable; rdata only updates when set
//   we     in  write enable
//   addr   in  word index
//   wdata  in  write word
//   rdata  out registered read word
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage MIPS pipeline.
// Owns the EX/MEM register, the data RAM, an LED output register and a
// switch input port, and produces the registered MEM/WB outputs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Stall                    hold both pipeline registers, block writes
//   Flush                    load a bubble into EX/MEM
//   RegWriteIn .. WriteRegIn control/data from execute
//   SwitchIn                 board switches (read at SW_ADDR)
//   RegWriteOut .. ReadData  MEM/WB outputs to write-back
//   LedOut                   LED register (written at LED_ADDR)
//   ExMem*                   EX/MEM copies for forwarding
module memory_stage
  import mips_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [WORD_W-1:0] LED_ADDR    = LED_ADDR_DEF,
  parameter logic [WORD_W-1:0] SW_ADDR     = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              RegWriteIn,
  input  logic              MemToRegIn,
  input  logic              MemWriteIn,
  input  logic [WORD_W-1:0] ALUResultIn,
  input  logic [WORD_W-1:0] WriteDataIn,
  input  logic [REG_W-1:0]  WriteRegIn,
  input  logic [15:0]       SwitchIn,
  output logic              RegWriteOut,
  output logic              MemToRegOut,
  output logic [WORD_W-1:0] ALUResultOut,
  output logic [WORD_W-1:0] ReadData,
  output logic [REG_W-1:0]  WriteRegOut,
  output logic [15:0]       LedOut,
  output logic              ExMemRegWrite,
  output logic [REG_W-1:0]  ExMemWriteReg,
  output logic [WORD_W-1:0] ExMemALUResult
);

  localparam int                ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] RAM_BYTES = WORD_W'(DEPTH_WORDS * 4);

  logic              reg_write_p1;
  logic              mem_to_reg_p1;
  logic              mem_write_p1;
  logic [WORD_W-1:0] alu_p1;
  logic [WORD_W-1:0] wdata_p1;
  logic [REG_W-1:0]  wreg_p1;

  memwb_t            memwb_p2;
  rd_src_e           rd_src_p2;
  logic [15:0]       sw_p2;
  logic [WORD_W-1:0] ram_rdata_p2;
  logic [15:0]       led;

  logic              ram_hit;
  logic              led_hit;
  logic              sw_hit;
  logic              wr_ok;
  rd_src_e           rd_src;

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_p1        <= '0;
      wdata_p1      <= '0;
      wreg_p1       <= '0;
    end else if (!Stall) begin
      reg_write_p1  <= RegWriteIn;
      mem_to_reg_p1 <= MemToRegIn;
      mem_write_p1  <= MemWriteIn;
      alu_p1        <= ALUResultIn;
      wdata_p1      <= WriteDataIn;
      wreg_p1       <= WriteRegIn;
    end
  end

  assign ExMemRegWrite  = reg_write_p1;
  assign ExMemWriteReg  = wreg_p1;
  assign ExMemALUResult = alu_p1;

  assign ram_hit = (alu_p1 < RAM_BYTES);
  assign led_hit = (alu_p1 == LED_ADDR);
  assign sw_hit  = (alu_p1 == SW_ADDR);
  // rst is included so a store sitting in EX/MEM at reset is dropped.
  assign wr_ok   = mem_write_p1 && !Stall && !rst;

  always_comb begin
    rd_src = RD_ZERO;
    if (ram_hit) begin
      rd_src = RD_RAM;
    end else if (sw_hit) begin
      rd_src = RD_SW;
    end
  end

  // The RAM output register is part of the MEM/WB stage: it only advances
  // when MEM/WB loads, so a stall keeps ReadData stable.
  data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .en    (ram_hit && !Stall && !rst),
    .we    (wr_ok && ram_hit),
    .addr  (alu_p1[ADDR_W+1:2]),
    .wdata (wdata_p1),
    .rdata (ram_rdata_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (wr_ok && led_hit) begin
      led <= wdata_p1[15:0];
    end
  end

  assign LedOut = led;

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_p2  <= '0;
      rd_src_p2 <= RD_ZERO;
      sw_p2     <= '0;
    end else if (!Stall) begin
      memwb_p2.reg_write  <= reg_write_p1;
      memwb_p2.mem_to_reg <= mem_to_reg_p1;
      memwb_p2.alu_result <= alu_p1;
      memwb_p2.write_reg  <= wreg_p1;
      rd_src_p2           <= rd_src;
      sw_p2               <= SwitchIn;
    end
  end

  assign RegWriteOut  = memwb_p2.reg_write;
  assign MemToRegOut  = memwb_p2.mem_to_reg;
  assign ALUResultOut = memwb_p2.alu_result;
  assign WriteRegOut  = memwb_p2.write_reg;

  // Only registered values feed this mux, so ReadData behaves as a register.
  always_comb begin
    ReadData = '0;
    case (rd_src_p2)
      RD_RAM:  ReadData = ram_rdata_p2;
      RD_SW:   ReadData = {16'h0000, sw_p2};
      default: ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Flush;
  logic        RegWriteIn, MemToRegIn, MemWriteIn;
  logic [31:0] ALUResultIn, WriteDataIn;
  logic [4:0]  WriteRegIn;
  logic [15:0] SwitchIn;
  logic        RegWriteOut, MemToRegOut;
  logic [31:0] ALUResultOut, ReadData;
  logic [4:0]  WriteRegOut;
  logic [15:0] LedOut;
  logic        ExMemRegWrite;
  logic [4:0]  ExMemWriteReg;
  logic [31:0] ExMemALUResult;

  memory_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .MemWriteIn(MemWriteIn),
    .ALUResultIn(ALUResultIn), .WriteDataIn(WriteDataIn), .WriteRegIn(WriteRegIn),
    .SwitchIn(SwitchIn),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .ALUResultOut(ALUResultOut), .ReadData(ReadData), .WriteRegOut(WriteRegOut),
    .LedOut(LedOut), .ExMemRegWrite(ExMemRegWrite), .ExMemWriteReg(ExMemWriteReg),
    .ExMemALUResult(ExMemALUResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [4:0]  wr;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  last_tag = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: each new non-zero destination tag on the MEM/WB side is one
  // retired instruction; pop and compare against the scoreboard.
  always @(negedge clk) begin
    if (WriteRegOut != 5'd0 && WriteRegOut != last_tag) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: got tag %0d expected none", WriteRegOut);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wb_tag", {27'd0, WriteRegOut}, {27'd0, e.wr});
        check("wb_regwrite", {31'd0, RegWriteOut}, {31'd0, e.rw});
        check("wb_memtoreg", {31'd0, MemToRegOut}, {31'd0, e.m2r});
        check("wb_alu", ALUResultOut, e.alu);
        if (e.chk_rd) check("wb_readdata", ReadData, e.rd);
      end
    end
    last_tag = WriteRegOut;
  end

  // Called at a negedge; drives one instruction for one rising edge.
  task automatic issue(input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input bit flush, input bit push,
                       input bit chk, input logic [31:0] rd);
    exp_t e;
    RegWriteIn = rw; MemToRegIn = m2r; MemWriteIn = mw;
    ALUResultIn = alu; WriteDataIn = wd; WriteRegIn = wr; Flush = flush;
    if (push) begin
      e.rw = rw; e.m2r = m2r; e.alu = alu; e.wr = wr; e.chk_rd = chk; e.rd = rd;
      sbq.push_back(e);
    end
    @(negedge clk);
    Flush = 1'b0;
  endtask

  task automatic nop();
    issue(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regwrite"}, {31'd0, RegWriteOut}, 32'd0);
    check({tag, "_memtoreg"}, {31'd0, MemToRegOut}, 32'd0);
    check({tag, "_alu"}, ALUResultOut, 32'd0);
    check({tag, "_readdata"}, ReadData, 32'd0);
    check({tag, "_writereg"}, {27'd0, WriteRegOut}, 32'd0);
    check({tag, "_led"}, {16'd0, LedOut}, 32'd0);
    check({tag, "_fwd_rw"}, {31'd0, ExMemRegWrite}, 32'd0);
    check({tag, "_fwd_wr"}, {27'd0, ExMemWriteReg}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic        s_rw;
  logic [31:0] s_alu, s_rd;
  logic [4:0]  s_wr;

  initial begin
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    RegWriteIn = 0; MemToRegIn = 0; MemWriteIn = 0;
    ALUResultIn = 0; WriteDataIn = 0; WriteRegIn = 0;
    SwitchIn = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Plain ALU op; forwarding copies visible after one edge.
    issue(1, 0, 0, 32'h10, 32'h0, 5'd8, 0, 1, 0, 32'h0);
    check("fwd_regwrite", {31'd0, ExMemRegWrite}, 32'd1);
    check("fwd_writereg", {27'd0, ExMemWriteReg}, 32'd8);
    check("fwd_alu", ExMemALUResult, 32'h10);

    // Store then immediate load of the same word, plus unaligned alias.
    issue(0, 0, 1, 32'h40, 32'hDEADBEEF, 5'd9, 0, 1, 0, 32'h0);
    issue(1, 1, 0, 32'h40, 32'h0, 5'd10, 0, 1, 1, 32'hDEADBEEF);
    issue(1, 1, 0, 32'h43, 32'h0, 5'd11, 0, 1, 1, 32'hDEADBEEF);

    // MMIO.
    issue(0, 0, 1, 32'hFFFF_FFF0, 32'h0001_A5A5, 5'd12, 0, 1, 0, 32'h0);
    issue(1, 1, 0, 32'hFFFF_FFF0, 32'h0, 5'd13, 0, 1, 1, 32'h0);
    check("led_write", {16'd0, LedOut}, 32'h0000_A5A5);
    issue(1, 1, 0, 32'hFFFF_FFF4, 32'h0, 5'd14, 0, 1, 1, 32'h0000_1234);
    issue(1, 1, 0, 32'h8000_0000, 32'h0, 5'd15, 0, 1, 1, 32'h0);
    issue(0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0, 1, 0, 32'h0);
    issue(1, 1, 0, 32'h40, 32'h0, 5'd17, 0, 1, 1, 32'hDEADBEEF);
    check("led_after_unmapped", {16'd0, LedOut}, 32'h0000_A5A5);

    // Stall a store in EX/MEM for three cycles; the following load waits.
    issue(0, 0, 1, 32'h44, 32'h1111_2222, 5'd18, 0, 1, 0, 32'h0);
    s_rw = RegWriteOut; s_alu = ALUResultOut; s_rd = ReadData; s_wr = WriteRegOut;
    RegWriteIn = 1; MemToRegIn = 1; MemWriteIn = 0;
    ALUResultIn = 32'h44; WriteDataIn = 0; WriteRegIn = 5'd19;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_writereg", {27'd0, WriteRegOut}, {27'd0, s_wr});
      check("stall_regwrite", {31'd0, RegWriteOut}, {31'd0, s_rw});
      check("stall_alu", ALUResultOut, s_alu);
      check("stall_readdata", ReadData, s_rd);
      check("stall_exmem_wr", {27'd0, ExMemWriteReg}, 32'd18);
    end
    Stall = 1'b0;
    issue(1, 1, 0, 32'h44, 32'h0, 5'd19, 0, 1, 1, 32'h1111_2222);

    // Flushed store never writes and never retires.
    issue(0, 0, 1, 32'h40, 32'h5555_5555, 5'd20, 1, 0, 0, 32'h0);
    nop();
    check("flush_regwrite", {31'd0, RegWriteOut}, 32'd0);
    check("flush_writereg", {27'd0, WriteRegOut}, 32'd0);
    issue(1, 1, 0, 32'h40, 32'h0, 5'd21, 0, 1, 1, 32'hDEADBEEF);

    // Flush+Stall: EX/MEM becomes a bubble, MEM/WB keeps tag 22.
    issue(1, 1, 0, 32'h44, 32'h0, 5'd22, 0, 1, 1, 32'h1111_2222);
    issue(1, 1, 0, 32'h40, 32'h0, 5'd23, 0, 0, 0, 32'h0);
    RegWriteIn = 0; MemToRegIn = 0; MemWriteIn = 0;
    ALUResultIn = 0; WriteDataIn = 0; WriteRegIn = 0;
    Flush = 1'b1; Stall = 1'b1;
    @(negedge clk);
    Flush = 1'b0; Stall = 1'b0;
    check("fs_exmem_rw", {31'd0, ExMemRegWrite}, 32'd0);
    check("fs_exmem_wr", {27'd0, ExMemWriteReg}, 32'd0);
    check("fs_memwb_wr", {27'd0, WriteRegOut}, 32'd22);
    check("fs_memwb_rd", ReadData, 32'h1111_2222);
    nop();
    nop();

    // Reset while a store sits in EX/MEM.
    issue(0, 0, 1, 32'h40, 32'h9999_9999, 5'd24, 0, 0, 0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    issue(1, 1, 0, 32'h40, 32'h0, 5'd25, 0, 1, 1, 32'hDEADBEEF);
    issue(1, 1, 0, 32'h44, 32'h0, 5'd26, 0, 1, 1, 32'h1111_2222);
    nop();
    nop();
    nop();

    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the 5-stage 32-bit MIPS pipeline. It owns the EX/MEM pipeline register, the word-addressed data memory and a small memory-mapped I/O window. It also produces the registered MEM/WB outputs consumed by write-back. It sits directly downstream of the execute stage and takes that stage's control, ALU result, store data and destination register.

## Interface
- DEPTH_WORDS, 1024, data memory depth in 32-bit words (power of two)
- LED_ADDR, 32'hFFFF_FFF0, byte address of the write-only LED register
- SW_ADDR, 32'hFFFF_FFF4, byte address of the read-only switch port

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Stall  in  1  hold both pipeline registers; suppress memory/LED writes
- Flush  in  1  load a bubble into EX/MEM
- RegWriteIn, MemToRegIn, MemWriteIn  in  1 each  control from execute
- ALUResultIn  in  32  byte address / ALU result
- WriteDataIn  in  32  store data
- WriteRegIn  in  5  destination register
- SwitchIn  in  16  board switches
- RegWriteOut, MemToRegOut  out  1 each  MEM/WB control
- ALUResultOut  out  32  MEM/WB ALU result
- ReadData  out  32  MEM/WB load data
- WriteRegOut  out  5  MEM/WB destination
- LedOut  out  16  LED register
- ExMemRegWrite  out  1  EX/MEM RegWrite, for forwarding
- ExMemWriteReg  out  5  EX/MEM destination, for forwarding
- ExMemALUResult  out  32  EX/MEM ALU result, for forwarding

## Operation
- EX/MEM register: captures all *In signals each edge, with priority rst > Flush > Stall > load.
  - Flush clears RegWrite, MemToReg and MemWrite. Data fields are don't-care but are cleared to 0.
- Address decode (on the EX/MEM address A):
  - RAM hit: A < DEPTH_WORDS*4. Word index = A[log2(DEPTH_WORDS)+1:2]; A[1:0] is ignored.
  - LED hit: A == LED_ADDR.
  - SW hit: A == SW_ADDR.
  - Anything else is unmapped.
- Write:
  - Happens when EX/MEM MemWrite=1, Stall=0 and rst=0.
  - A RAM hit writes the word.
  - An LED hit loads LedOut ← WriteData[15:0].
  - SW and unmapped writes are ignored.
- Read data, registered into ReadData at the same edge that loads MEM/WB:
  - RAM hit → word at the index, using synchronous read.
  - SW hit → {16'b0, SwitchIn}.
  - LED or unmapped → 32'h0.
- Read-during-write at the same RAM index in the same cycle returns the old contents. The pipeline never issues both for one instruction.
- MEM/WB register: captures EX/MEM RegWrite, MemToReg, ALUResult and WriteReg, plus the read data.
  - It holds while Stall=1.
  - Flush does not affect MEM/WB.
- RAM contents are not reset. All pipeline register fields, LedOut and ReadData reset to 0.

## Timing
- Inputs presented in cycle N are captured in EX/MEM at the end of N.
- Memory/LED writes commit at the end of N+1.
- MEM/WB outputs are valid in cycle N+2. Latency is 2 edges.
- Store then load to the same address in the next instruction: the load reads the new value.
- Stall held for k cycles extends latency by k. No write is duplicated or lost, and outputs are stable throughout.
- Flush and Stall asserted together: the bubble is loaded into EX/MEM and MEM/WB holds.
- rst mid-operation: at the next edge all registers are cleared and any pending store is dropped. RAM keeps its prior contents.
- Forwarding outputs are combinational copies of the EX/MEM register.

## Structure
- Shared package mips_pkg holds:
  - word width, register-index width;
  - LED_ADDR and SW_ADDR defaults;
  - a packed struct for the MEM/WB bundle.
- One sub-module, data_memory: single port, synchronous write, synchronous read, parameterised DEPTH_WORDS.
- Decode and the pipeline registers live in memory_stage.

## Test plan
- Reset: after rst=1 for 1 cycle, all outputs are 0. Set inputs to RegWrite=1, ALUResult=32'h10, WriteReg=5'd8. Two edges later: RegWriteOut=1, ALUResultOut=32'h10, WriteRegOut=8.
- Store/load: store 32'hDEADBEEF to A=32'h40, then immediately load A=32'h40. The load's ReadData is 32'hDEADBEEF. A load from A=32'h43 returns the same word.
- MMIO: store 32'h0001_A5A5 to LED_ADDR, then LedOut=16'hA5A5. With SwitchIn=16'h1234, a load from SW_ADDR returns 32'h0000_1234. A load from 32'h8000_0000 returns 0 and a store there changes nothing.
- Stall: stall a store for 3 cycles. Memory is written exactly once, after the stall releases. Outputs are unchanged during the stall.
- Flush: flush a store to 32'h40. The word is unchanged and RegWriteOut=0 two cycles later. Flush+Stall together: EX/MEM becomes a bubble and MEM/WB holds.
- Reset mid-operation: assert rst while a store is in EX/MEM. The store is dropped and previously written RAM words are unchanged.
